// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine phase timer: FSM state encoding
// and default phase durations.
package wm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WASH_RUN  = 3'd1,
      ST_WASH_DONE = 3'd2,
      ST_SPIN_RUN  = 3'd3,
      ST_SPIN_DONE = 3'd4
   } wm_state_e;

   localparam int DEF_PRESCALE   = 100;
   localparam int DEF_WASH_TICKS = 30;
   localparam int DEF_SPIN_TICKS = 10;
   localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/wm_tick_gen.sv
// Prescaler for the phase timer: counts 0..PRESCALE-1 while enabled and
// pulses tick_o for one cycle on the last count.
module wm_tick_gen #(
   parameter int PRESCALE = 100,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer feeding the washing-machine controller's timeout inputs.
// Optional WM_PAUSE_EN adds a 'pause' input that freezes phase timing.
module wm_phase_timer
   import wm_pkg::*;
#(
   parameter int PRESCALE   = DEF_PRESCALE,
   parameter int WASH_TICKS = DEF_WASH_TICKS,
   parameter int SPIN_TICKS = DEF_SPIN_TICKS,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             door_lock,
   input  logic             motor_on,
   input  logic             drain_value_on,
   input  logic             soap_wash,
   input  logic             water_wash,
`ifdef WM_PAUSE_EN
   input  logic             pause,
`endif
   output logic             cycle_timeout,
   output logic             spin_timeout,
   output logic [CNT_W-1:0] tick_count,
   output logic             busy
);

   localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_TICKS - 1);
   localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_TICKS - 1);

   wm_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             cto_q, sto_q;
   logic [1:0]       phase_q;
   logic             wash_req, spin_req, phase_chg;
   logic             running, hold, tick_en, tick, presc_clr;

`ifdef WM_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign wash_req  = door_lock & motor_on & ~drain_value_on;
   assign spin_req  = door_lock & motor_on & drain_value_on;
   assign phase_chg = ({soap_wash, water_wash} != phase_q);
   assign running   = (state_q == ST_WASH_RUN) || (state_q == ST_SPIN_RUN);
   assign tick_en   = running & ~hold;

   wm_tick_gen #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_tick_gen (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (presc_clr),
      .enable_i (tick_en),
      .tick_o   (tick)
   );

   // Priority: abort/exit, then spin request, then phase change, then tick.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      presc_clr = 1'b0;
      if (!door_lock || !motor_on) begin
         state_d   = ST_IDLE;
         count_d   = '0;
         presc_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = spin_req ? ST_SPIN_RUN : ST_WASH_RUN;
               count_d   = '0;
               presc_clr = 1'b1;
            end
            ST_WASH_RUN, ST_WASH_DONE: begin
               if (spin_req) begin
                  state_d   = ST_SPIN_RUN;
                  count_d   = '0;
                  presc_clr = 1'b1;
               end else if (phase_chg) begin
                  state_d   = ST_WASH_RUN;
                  count_d   = '0;
                  presc_clr = 1'b1;
               end else if ((state_q == ST_WASH_RUN) && tick) begin
                  count_d = count_q + CNT_W'(1);
                  if (count_q == WASH_LAST) state_d = ST_WASH_DONE;
               end
            end
            ST_SPIN_RUN: begin
               if (tick) begin
                  count_d = count_q + CNT_W'(1);
                  if (count_q == SPIN_LAST) state_d = ST_SPIN_DONE;
               end
            end
            ST_SPIN_DONE: begin
               state_d = ST_SPIN_DONE;
            end
            default: begin
               state_d   = ST_IDLE;
               count_d   = '0;
               presc_clr = 1'b1;
            end
         endcase
      end
   end

   // Timeouts are registered copies of "next state is a DONE state", so they
   // rise on the expiry edge and drop on any edge that leaves DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         cto_q   <= 1'b0;
         sto_q   <= 1'b0;
         phase_q <= 2'b00;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         cto_q   <= (state_d == ST_WASH_DONE);
         sto_q   <= (state_d == ST_SPIN_DONE);
         phase_q <= {soap_wash, water_wash};
      end
   end

   assign cycle_timeout = cto_q;
   assign spin_timeout  = sto_q;
   assign tick_count    = count_q;
   assign busy          = running;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Self-checking bench for wm_phase_timer against an elapsed-cycle reference
// model; define WM_PAUSE_EN to also exercise the pause input.
module tb_wm_phase_timer;

   localparam int PS = 4;
   localparam int WT = 3;
   localparam int ST = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          doorLock, motorOn, drainOn, soapWash, waterWash, pauseIn;
   logic          cycleTimeout, spinTimeout, busy;
   logic [CW-1:0] tickCount;

   // Reference model: mode 0=idle, 1=wash, 2=spin; elapsed counts active
   // cycles in the current phase, saturating at the phase length.
   int            mode;
   int            elapsed;
   logic [1:0]    prevPhase;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   wm_phase_timer #(
      .PRESCALE   (PS),
      .WASH_TICKS (WT),
      .SPIN_TICKS (ST),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .door_lock      (doorLock),
      .motor_on       (motorOn),
      .drain_value_on (drainOn),
      .soap_wash      (soapWash),
      .water_wash     (waterWash),
`ifdef WM_PAUSE_EN
      .pause          (pauseIn),
`endif
      .cycle_timeout  (cycleTimeout),
      .spin_timeout   (spinTimeout),
      .tick_count     (tickCount),
      .busy           (busy)
   );

   function automatic int limitOf(input int m);
      return (m == 1) ? WT * PS : ST * PS;
   endfunction

   task automatic modelReset();
      mode      = 0;
      elapsed   = 0;
      prevPhase = 2'b00;
   endtask

   task automatic modelEdge();
      logic [1:0] ph;
      ph = {soapWash, waterWash};
      if (!doorLock || !motorOn) begin
         mode    = 0;
         elapsed = 0;
      end else if (mode == 0) begin
         mode    = drainOn ? 2 : 1;
         elapsed = 0;
      end else if (mode == 1 && drainOn) begin
         mode    = 2;
         elapsed = 0;
      end else if (mode == 1 && ph != prevPhase) begin
         elapsed = 0;
      end else if (!pauseIn && elapsed < limitOf(mode)) begin
         elapsed = elapsed + 1;
      end
      prevPhase = ph;
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass,
   // advance the model, and return at the next falling edge.
   task automatic applyStimulus(input logic dl, input logic mo, input logic dr,
                                input logic so, input logic wa, input logic pa);
      doorLock  = dl;
      motorOn   = mo;
      drainOn   = dr;
      soapWash  = so;
      waterWash = wa;
`ifdef WM_PAUSE_EN
      pauseIn   = pa;
`else
      pauseIn   = 1'b0 & pa;
`endif
      @(posedge clk);
      if (reset) modelEdge();
      else modelReset();
      @(negedge clk);
   endtask

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      int lim;
      lim = limitOf(mode);
      checkOne({tag, "_busy"}, 32'(busy), 32'((mode != 0 && elapsed < lim) ? 1 : 0));
      checkOne({tag, "_cto"},  32'(cycleTimeout), 32'((mode == 1 && elapsed == lim) ? 1 : 0));
      checkOne({tag, "_sto"},  32'(spinTimeout),  32'((mode == 2 && elapsed == lim) ? 1 : 0));
      checkOne({tag, "_tick"}, 32'(tickCount),    32'(elapsed / PS));
   endtask

   initial begin
      logic so, wa, dr;
      modelReset();
      reset = 1'b0;
      {doorLock, motorOn, drainOn, soapWash, waterWash} = 5'($urandom);
      pauseIn = 1'b0;

      // Reset held with random inputs: everything stays cleared.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         {doorLock, motorOn, drainOn, soapWash, waterWash} = 5'($urandom);
         #1;
         checkOne("rst_busy", 32'(busy), 32'd0);
         checkOne("rst_cto",  32'(cycleTimeout), 32'd0);
         checkOne("rst_sto",  32'(spinTimeout), 32'd0);
         checkOne("rst_tick", 32'(tickCount), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("idle");

      // Soap wash: expires exactly 12 edges after entry.
      applyStimulus(1, 1, 0, 1, 0, 0);
      checkOutput("wash_entry");
      checkOne("wash_entry_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= WT * PS; i++) begin
         applyStimulus(1, 1, 0, 1, 0, 0);
         checkOutput("wash");
         if (i == WT * PS - 1) checkOne("wash_pre_cto", 32'(cycleTimeout), 32'd0);
      end
      checkOne("wash_cto", 32'(cycleTimeout), 32'd1);
      checkOne("wash_tick", 32'(tickCount), 32'(WT));

      // Soap to water restarts wash timing.
      applyStimulus(1, 1, 0, 0, 1, 0);
      checkOutput("rinse_entry");
      checkOne("rinse_clr_cto", 32'(cycleTimeout), 32'd0);
      for (int i = 1; i <= WT * PS; i++) begin
         applyStimulus(1, 1, 0, 0, 1, 0);
         checkOutput("rinse");
      end
      checkOne("rinse_cto", 32'(cycleTimeout), 32'd1);

      // Wash to spin, spin expiry, then exit on motor off.
      applyStimulus(1, 1, 1, 0, 1, 0);
      checkOutput("spin_entry");
      checkOne("spin_clr_cto", 32'(cycleTimeout), 32'd0);
      for (int i = 1; i <= ST * PS; i++) begin
         applyStimulus(1, 1, 1, 0, 1, 0);
         checkOutput("spin");
      end
      checkOne("spin_sto", 32'(spinTimeout), 32'd1);
      applyStimulus(1, 0, 1, 0, 1, 0);
      checkOutput("spin_exit");
      checkOne("spin_exit_sto", 32'(spinTimeout), 32'd0);

      // Abort in mid-wash at tick_count 1.
      applyStimulus(1, 1, 0, 1, 0, 0);
      for (int i = 1; i <= PS; i++) applyStimulus(1, 1, 0, 1, 0, 0);
      checkOne("abort_pre_tick", 32'(tickCount), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0, 1, 0, 0);
         checkOutput("abort");
      end
      checkOne("abort_busy", 32'(busy), 32'd0);

`ifdef WM_PAUSE_EN
      // Five paused cycles stretch the wash to 17 edges.
      applyStimulus(1, 0, 0, 1, 0, 0);
      applyStimulus(1, 1, 0, 1, 0, 0);
      for (int i = 1; i <= WT * PS + 5; i++) begin
         applyStimulus(1, 1, 0, 1, 0, (i >= 4 && i <= 8) ? 1'b1 : 1'b0);
         checkOutput("pause");
         if (i == WT * PS + 4) checkOne("pause_pre_cto", 32'(cycleTimeout), 32'd0);
      end
      checkOne("pause_cto", 32'(cycleTimeout), 32'd1);
      applyStimulus(1, 0, 0, 1, 0, 0);
`endif

      // Randomized traffic against the model.
      so = 1'b1;
      wa = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) {so, wa} = 2'($urandom);
         dr = (mode == 2) ? 1'b1 : ($urandom_range(9) == 0);
         applyStimulus($urandom_range(15) != 0, $urandom_range(11) != 0, dr, so, wa,
                       $urandom_range(3) == 0);
         checkOutput("rand");
      end

      // Asynchronous reset while in spin-done.
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 0);
      for (int i = 1; i <= ST * PS; i++) applyStimulus(1, 1, 1, 0, 0, 0);
      checkOne("async_pre_sto", 32'(spinTimeout), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkOne("async_sto",  32'(spinTimeout), 32'd0);
      checkOne("async_busy", 32'(busy), 32'd0);
      checkOne("async_tick", 32'(tickCount), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("post_async");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
